// File: rtl/sd_loader_pkg.sv
// sd_loader_pkg: states, card register map and constants
// shared by the sector loader and its bus masters.
package sd_loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHK,
    S_ARG,
    S_CMD,
    S_POLL,
    S_RDB,
    S_WRS,
    S_NXT,
    S_FIN
  } state_t;

  localparam logic [7:0] REG_ARG = 8'd139;
  localparam logic [7:0] REG_CMD = 8'd140;
  localparam logic [7:0] REG_ASR = 8'd141;

  localparam int ASR_PRESENT = 1;
  localparam int ASR_BUSY    = 2;
  localparam int ASR_ERR     = 3;

  localparam logic [31:0] READ_BLOCK = 32'd17;
  localparam int SECTOR_WORDS = 128;

  // SDSC cards take a byte address, SDHC a block number
  function automatic logic [31:0] sector_arg(
    input logic [31:0] sec,
    input bit          block
  );
    return block ? sec : {sec[22:0], 9'd0};
  endfunction

endpackage

// File: rtl/avalon_single_master.sv
// avalon_single_master: one Avalon-MM transaction at a time,
// held on the bus until the slave drops waitrequest.
module avalon_single_master #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          req,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ack,
  output logic          chipselect,
  output logic          read,
  output logic          write,
  output logic [AW-1:0] address,
  output logic [DW-1:0] writedata,
  input  logic          waitrequest
);

  // the requester keeps req/addr/wdata steady until ack
  always_comb begin
    chipselect = req;
    read       = req & ~wr;
    write      = req & wr;
    address    = req ? addr : '0;
    writedata  = (req & wr) ? wdata : '0;
    ack        = req & ~waitrequest;
  end

endmodule

// File: rtl/sd_sector_loader.sv
// sd_sector_loader: copies a run of SD card sectors into SDRAM
// through two Avalon-MM master ports, one transaction at a time.
module sd_sector_loader
  import sd_loader_pkg::*;
#(
  parameter int SDRAM_DW    = 16,
  parameter int SDRAM_AW    = 25,
  parameter int CNT_W       = 16,
  parameter int BLOCK_ADDR  = 0,
  parameter int SWAP_HALVES = 0
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [31:0]           start_sector,
  input  logic [CNT_W-1:0]      num_sectors,
  input  logic [SDRAM_AW-1:0]   sdram_base,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  aborted,
  output logic [CNT_W-1:0]      sectors_done,
  output logic                  sd_chipselect,
  output logic                  sd_read,
  output logic                  sd_write,
  output logic [7:0]            sd_address,
  output logic [3:0]            sd_byteenable,
  output logic [31:0]           sd_writedata,
  input  logic [31:0]           sd_readdata,
  input  logic                  sd_waitrequest,
  output logic                  sdr_chipselect,
  output logic [SDRAM_AW-1:0]   sdr_address,
  output logic [SDRAM_DW-1:0]   sdr_writedata,
  output logic [SDRAM_DW/8-1:0] sdr_byteenable_n,
  output logic                  sdr_write_n,
  output logic                  sdr_read_n,
  input  logic                  sdr_waitrequest
);

  localparam int NPARTS = 32 / SDRAM_DW;

  state_t state, nxt;

  logic [31:0]         cur_sector;
  logic [CNT_W-1:0]    num_q;
  logic [CNT_W-1:0]    done_cnt;
  logic [6:0]          word_idx;
  logic [1:0]          part;
  logic [1:0]          chunk;
  logic [31:0]         word_q;
  logic [SDRAM_AW-1:0] sdr_addr_q;
  logic                err_q;
  logic                abt_q;

  logic                sd_req;
  logic                sd_wr;
  logic                sd_ack;
  logic [7:0]          sd_addr_c;
  logic [31:0]         sd_wdata_c;
  logic                sdr_req;
  logic                sdr_ack;
  logic                sdr_rd;
  logic                sdr_wr;
  logic [SDRAM_DW-1:0] sdr_wdata_c;

  logic last_part;
  logic last_word;
  logic last_sec;
  logic set_err;
  logic set_abt;

  assign last_part = part == 2'(NPARTS - 1);
  assign last_word = word_idx == 7'(SECTOR_WORDS - 1);
  assign last_sec  = (done_cnt + CNT_W'(1)) == num_q;

  always_comb begin
    nxt        = state;
    sd_req     = 1'b0;
    sd_wr      = 1'b0;
    sd_addr_c  = '0;
    sd_wdata_c = '0;
    sdr_req    = 1'b0;
    set_err    = 1'b0;
    set_abt    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start)
          nxt = (num_sectors == '0) ? S_FIN : S_CHK;
      end
      S_CHK: begin
        sd_req    = 1'b1;
        sd_addr_c = REG_ASR;
        if (sd_ack) begin
          set_err = ~sd_readdata[ASR_PRESENT];
          nxt = sd_readdata[ASR_PRESENT] ? S_ARG : S_FIN;
        end
      end
      S_ARG: begin
        sd_req     = 1'b1;
        sd_wr      = 1'b1;
        sd_addr_c  = REG_ARG;
        sd_wdata_c = sector_arg(cur_sector, BLOCK_ADDR != 0);
        if (sd_ack)
          nxt = S_CMD;
      end
      S_CMD: begin
        sd_req     = 1'b1;
        sd_wr      = 1'b1;
        sd_addr_c  = REG_CMD;
        sd_wdata_c = READ_BLOCK;
        if (sd_ack) begin
          set_abt = abort;
          nxt = abort ? S_FIN : S_POLL;
        end
      end
      S_POLL: begin
        sd_req    = 1'b1;
        sd_addr_c = REG_ASR;
        if (sd_ack) begin
          if (abort) begin
            set_abt = 1'b1;
            nxt     = S_FIN;
          end else if (sd_readdata[ASR_BUSY]) begin
            nxt = S_POLL;
          end else if (sd_readdata[ASR_ERR]) begin
            set_err = 1'b1;
            nxt     = S_FIN;
          end else begin
            nxt = S_RDB;
          end
        end
      end
      S_RDB: begin
        sd_req    = 1'b1;
        sd_addr_c = {1'b0, word_idx};
        if (sd_ack) begin
          set_abt = abort;
          nxt = abort ? S_FIN : S_WRS;
        end
      end
      S_WRS: begin
        sdr_req = 1'b1;
        if (sdr_ack) begin
          set_abt = abort;
          if (abort)
            nxt = S_FIN;
          else if (!last_part)
            nxt = S_WRS;
          else if (!last_word)
            nxt = S_RDB;
          else if (last_sec)
            nxt = S_FIN;
          else
            nxt = S_NXT;
        end
      end
      S_NXT:   nxt = S_ARG;
      S_FIN:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    chunk = (SWAP_HALVES != 0) ? 2'(NPARTS - 1) - part : part;
    sdr_wdata_c = word_q[chunk*SDRAM_DW +: SDRAM_DW];
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= S_IDLE;
      cur_sector <= '0;
      num_q      <= '0;
      done_cnt   <= '0;
      word_idx   <= '0;
      part       <= '0;
      word_q     <= '0;
      sdr_addr_q <= '0;
      err_q      <= 1'b0;
      abt_q      <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && start) begin
        cur_sector <= start_sector;
        num_q      <= num_sectors;
        sdr_addr_q <= sdram_base;
        done_cnt   <= '0;
        word_idx   <= '0;
        part       <= '0;
        err_q      <= 1'b0;
        abt_q      <= 1'b0;
      end
      if (set_err)
        err_q <= 1'b1;
      if (set_abt)
        abt_q <= 1'b1;
      if (state == S_RDB && sd_ack)
        word_q <= sd_readdata;
      if (state == S_WRS && sdr_ack) begin
        sdr_addr_q <= sdr_addr_q + 1'b1;
        if (last_part) begin
          part     <= '0;
          word_idx <= word_idx + 1'b1;
          if (last_word)
            done_cnt <= done_cnt + CNT_W'(1);
        end else begin
          part <= part + 1'b1;
        end
      end
      if (state == S_NXT)
        cur_sector <= cur_sector + 32'd1;
    end
  end

  avalon_single_master #(
    .AW(8),
    .DW(32)
  ) u_sd (
    .req         (sd_req),
    .wr          (sd_wr),
    .addr        (sd_addr_c),
    .wdata       (sd_wdata_c),
    .ack         (sd_ack),
    .chipselect  (sd_chipselect),
    .read        (sd_read),
    .write       (sd_write),
    .address     (sd_address),
    .writedata   (sd_writedata),
    .waitrequest (sd_waitrequest)
  );

  avalon_single_master #(
    .AW(SDRAM_AW),
    .DW(SDRAM_DW)
  ) u_sdr (
    .req         (sdr_req),
    .wr          (1'b1),
    .addr        (sdr_addr_q),
    .wdata       (sdr_wdata_c),
    .ack         (sdr_ack),
    .chipselect  (sdr_chipselect),
    .read        (sdr_rd),
    .write       (sdr_wr),
    .address     (sdr_address),
    .writedata   (sdr_writedata),
    .waitrequest (sdr_waitrequest)
  );

  assign sd_byteenable    = sd_chipselect ? 4'hF : 4'h0;
  assign sdr_byteenable_n = '0;
  assign sdr_write_n      = ~sdr_wr;
  assign sdr_read_n       = ~sdr_rd;

  assign busy         = (state != S_IDLE) && (state != S_FIN);
  assign done         = state == S_FIN;
  assign error        = err_q;
  assign aborted      = abt_q;
  assign sectors_done = done_cnt;

endmodule

// File: tb/tb_sd_sector_loader.sv
// tb_sd_sector_loader: card + SDRAM slave models, a job table
// and hand sequences for zero-length, reset and swapped builds.
module tb_sd_sector_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- DUT 1: default build
  logic        start = 1'b0;
  logic        abort_r = 1'b0;
  logic [31:0] start_sector = '0;
  logic [15:0] num_sectors = '0;
  logic [24:0] sdram_base = '0;
  logic        busy, done, error, aborted;
  logic [15:0] sectors_done;
  logic        sd_cs, sd_rd, sd_wr;
  logic [7:0]  sd_addr;
  logic [3:0]  sd_be;
  logic [31:0] sd_wdata;
  logic [31:0] sd_rdata = '0;
  logic        sd_wait = 1'b0;
  logic        sdr_cs;
  logic [24:0] sdr_addr;
  logic [15:0] sdr_wdata;
  logic [1:0]  sdr_be_n;
  logic        sdr_write_n, sdr_read_n;
  logic        sdr_wait = 1'b0;

  sd_sector_loader dut (
    .clk_clk          (clk),
    .reset_reset_n    (rst_n),
    .start            (start),
    .abort            (abort_r),
    .start_sector     (start_sector),
    .num_sectors      (num_sectors),
    .sdram_base       (sdram_base),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .aborted          (aborted),
    .sectors_done     (sectors_done),
    .sd_chipselect    (sd_cs),
    .sd_read          (sd_rd),
    .sd_write         (sd_wr),
    .sd_address       (sd_addr),
    .sd_byteenable    (sd_be),
    .sd_writedata     (sd_wdata),
    .sd_readdata      (sd_rdata),
    .sd_waitrequest   (sd_wait),
    .sdr_chipselect   (sdr_cs),
    .sdr_address      (sdr_addr),
    .sdr_writedata    (sdr_wdata),
    .sdr_byteenable_n (sdr_be_n),
    .sdr_write_n      (sdr_write_n),
    .sdr_read_n       (sdr_read_n),
    .sdr_waitrequest  (sdr_wait)
  );

  // ---------------- DUT 2: SDHC addressing, upper half first
  logic        start2 = 1'b0;
  logic        busy2, done2, error2, aborted2;
  logic [15:0] sectors_done2;
  logic        sd2_cs, sd2_rd, sd2_wr;
  logic [7:0]  sd2_addr;
  logic [3:0]  sd2_be;
  logic [31:0] sd2_wdata;
  logic [31:0] sd2_rdata;
  logic        sdr2_cs;
  logic [24:0] sdr2_addr;
  logic [15:0] sdr2_wdata;
  logic [1:0]  sdr2_be_n;
  logic        sdr2_write_n, sdr2_read_n;

  sd_sector_loader #(
    .SDRAM_DW(16), .SDRAM_AW(25), .CNT_W(16),
    .BLOCK_ADDR(1), .SWAP_HALVES(1)
  ) dut2 (
    .clk_clk          (clk),
    .reset_reset_n    (rst_n),
    .start            (start2),
    .abort            (1'b0),
    .start_sector     (32'd5),
    .num_sectors      (16'd1),
    .sdram_base       (25'h40),
    .busy             (busy2),
    .done             (done2),
    .error            (error2),
    .aborted          (aborted2),
    .sectors_done     (sectors_done2),
    .sd_chipselect    (sd2_cs),
    .sd_read          (sd2_rd),
    .sd_write         (sd2_wr),
    .sd_address       (sd2_addr),
    .sd_byteenable    (sd2_be),
    .sd_writedata     (sd2_wdata),
    .sd_readdata      (sd2_rdata),
    .sd_waitrequest   (1'b0),
    .sdr_chipselect   (sdr2_cs),
    .sdr_address      (sdr2_addr),
    .sdr_writedata    (sdr2_wdata),
    .sdr_byteenable_n (sdr2_be_n),
    .sdr_write_n      (sdr2_write_n),
    .sdr_read_n       (sdr2_read_n),
    .sdr_waitrequest  (1'b0)
  );

  assign sd2_rdata = (sd2_addr == 8'd141) ? 32'h2
                                          : {24'hA50000, sd2_addr};

  logic [31:0] arg2 = '0;
  int          arg2_n = 0;
  logic [15:0] w2[$];

  always @(negedge clk) begin
    if (sd2_cs && sd2_wr && sd2_addr == 8'd139 && arg2_n == 0) begin
      arg2 = sd2_wdata;
      arg2_n++;
    end
    if (sdr2_cs && !sdr2_write_n)
      w2.push_back(sdr2_wdata);
  end

  // ---------------- card / SDRAM model for DUT 1
  bit card_present = 1'b1;
  int err_cmd = 0;
  int poll_busy = 0;
  bit stall_en = 1'b0;
  int abort_at = -1;
  int job_id = 0;

  int seen_job = 0;
  int cmd_count = 0;
  int poll_left = 0;
  int sd_stall = 0;
  int sdr_stall = 0;
  int sdr_count = 0;
  int done_count = 0;
  int overlap = 0;
  int cs_cycles = 0;
  logic [31:0] args[$];
  logic [15:0] mem[int];
  bit          sd_hold_v = 1'b0;
  logic [42:0] sd_hold = '0;
  bit          sdr_hold_v = 1'b0;
  logic [42:0] sdr_hold = '0;

  always @(negedge clk) begin
    logic [31:0] asr;
    logic [7:0]  tag;
    if (job_id != seen_job) begin
      seen_job   = job_id;
      cmd_count  = 0;
      poll_left  = 0;
      sd_stall   = 0;
      sdr_stall  = 0;
      sdr_count  = 0;
      done_count = 0;
      overlap    = 0;
      args.delete();
      mem.delete();
      abort_r <= 1'b0;
    end
    if (sd_cs && sdr_cs) overlap++;
    if (sd_cs || sdr_cs) cs_cycles++;
    if (done) done_count++;

    if (sd_hold_v)
      check("sd_stable", {sd_cs, sd_rd, sd_wr, sd_addr, sd_wdata}, sd_hold);
    sd_hold_v = 1'b0;
    if (sd_cs) begin
      asr    = '0;
      asr[1] = card_present;
      asr[2] = poll_left != 0;
      asr[3] = err_cmd != 0 && cmd_count == err_cmd;
      tag    = 8'(cmd_count - 1);
      if (sd_addr < 8'd128)
        sd_rdata <= {8'hA5, tag, 8'h00, sd_addr};
      else if (sd_addr == 8'd141)
        sd_rdata <= asr;
      else
        sd_rdata <= '0;
      if (sd_stall != 0) begin
        sd_wait  <= 1'b1;
        sd_stall--;
        sd_hold_v = 1'b1;
        sd_hold   = {sd_cs, sd_rd, sd_wr, sd_addr, sd_wdata};
      end else begin
        sd_wait <= 1'b0;
        if (sd_wr && sd_addr == 8'd139)
          args.push_back(sd_wdata);
        if (sd_wr && sd_addr == 8'd140 && sd_wdata == 32'd17) begin
          cmd_count++;
          poll_left = poll_busy;
        end
        if (sd_rd && sd_addr == 8'd141 && poll_left != 0)
          poll_left--;
        sd_stall = stall_en ? int'($urandom_range(0, 7)) : 0;
      end
    end else begin
      sd_wait <= 1'b0;
    end

    if (sdr_hold_v)
      check("sdr_stable", {sdr_cs, sdr_write_n, sdr_addr, sdr_wdata},
            sdr_hold);
    sdr_hold_v = 1'b0;
    if (sdr_cs) begin
      if (abort_at >= 0 && !sdr_write_n && sdr_count == abort_at)
        abort_r <= 1'b1;
      if (sdr_stall != 0) begin
        sdr_wait <= 1'b1;
        sdr_stall--;
        sdr_hold_v = 1'b1;
        sdr_hold   = {sdr_cs, sdr_write_n, sdr_addr, sdr_wdata};
      end else begin
        sdr_wait <= 1'b0;
        if (!sdr_write_n) begin
          mem[int'(sdr_addr)] = sdr_wdata;
          sdr_count++;
        end
        sdr_stall = stall_en ? int'($urandom_range(0, 7)) : 0;
      end
    end else begin
      sdr_wait <= 1'b0;
    end
  end

  // ---------------- job table
  typedef struct {
    logic [31:0] ss;
    int          num;
    logic [24:0] base;
    bit          present;
    int          err_cmd;
    int          poll;
    bit          stall;
    int          abort_at;
    int          exp_writes;
    bit          exp_err;
    bit          exp_abt;
    int          exp_sd;
    int          exp_nargs;
    logic [31:0] exp_arg0;
    logic [31:0] exp_argn;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [15:0] img(input int i);
    int s, k;
    s = i / 256;
    k = (i % 256) / 2;
    return (i % 2 == 1) ? {8'hA5, 8'(s)} : 16'(k);
  endfunction

  task automatic run_job(input vec_t v, input int idx);
    int  n;
    int  bad;
    bit  seen;
    int  a;
    card_present = v.present;
    err_cmd      = v.err_cmd;
    poll_busy    = v.poll;
    stall_en     = v.stall;
    abort_at     = v.abort_at;
    job_id++;
    @(negedge clk);
    start_sector = v.ss;
    num_sectors  = 16'(v.num);
    sdram_base   = v.base;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check($sformatf("j%0d_busy_start", idx), busy, 1);
    seen = done;
    while (!seen && n < 20000) begin
      @(negedge clk);
      n++;
      seen = done;
    end
    check($sformatf("j%0d_done_seen", idx), seen, 1);
    check($sformatf("j%0d_busy_at_done", idx), busy, 0);
    if (v.exp_cycles != 0)
      check($sformatf("j%0d_cycles", idx), n, v.exp_cycles);
    repeat (3) @(negedge clk);
    check($sformatf("j%0d_done_pulses", idx), done_count, 1);
    check($sformatf("j%0d_writes", idx), sdr_count, v.exp_writes);
    check($sformatf("j%0d_unique", idx), mem.num(), v.exp_writes);
    check($sformatf("j%0d_error", idx), error, v.exp_err);
    check($sformatf("j%0d_aborted", idx), aborted, v.exp_abt);
    check($sformatf("j%0d_sectors", idx), sectors_done, v.exp_sd);
    check($sformatf("j%0d_overlap", idx), overlap, 0);
    check($sformatf("j%0d_nargs", idx), args.size(), v.exp_nargs);
    if (v.exp_nargs > 0 && args.size() > 0) begin
      check($sformatf("j%0d_arg0", idx), args[0], v.exp_arg0);
      check($sformatf("j%0d_argn", idx), args[args.size()-1], v.exp_argn);
    end
    bad = 0;
    for (int i = 0; i < v.exp_writes; i++) begin
      a = int'(25'(v.base + 25'(i)));
      if (!mem.exists(a))
        bad++;
      else if (mem[a] !== img(i))
        bad++;
    end
    check($sformatf("j%0d_image", idx), bad, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"},
          {busy, done, error, aborted, sd_cs, sd_rd, sd_wr, sd_be,
           sdr_cs, sdr_write_n, sdr_read_n}, 14'b00000000000011);
    check({tag, "_sectors"}, sectors_done, 0);
    check({tag, "_sd_bus"}, {sd_addr, sd_wdata}, 0);
    check({tag, "_sdr_bus"}, {sdr_addr, sdr_wdata, sdr_be_n}, 0);
    check({tag, "_dut2"},
          {busy2, done2, error2, aborted2, sd2_cs, sd2_rd, sd2_wr,
           sd2_be, sdr2_cs, sdr2_write_n, sdr2_read_n, sectors_done2},
          {14'b00000000000011, 16'd0});
  endtask

  initial begin
    int  n;
    int  c0;
    bit  seen;

    vecs[0] = '{32'd5, 2, 25'h100, 1'b1, 0, 0, 1'b0, -1,
                512, 1'b0, 1'b0, 2, 2, 32'hA00, 32'hC00, 777};
    vecs[1] = '{32'h7FFFFF, 3, 25'h1FFFF80, 1'b1, 0, 3, 1'b1, -1,
                768, 1'b0, 1'b0, 3, 3, 32'hFFFFFE00, 32'h200, 0};
    vecs[2] = '{32'd9, 2, 25'h0, 1'b0, 0, 0, 1'b0, -1,
                0, 1'b1, 1'b0, 0, 0, 32'h0, 32'h0, 2};
    vecs[3] = '{32'd10, 3, 25'h40, 1'b1, 2, 1, 1'b0, -1,
                256, 1'b1, 1'b0, 1, 2, 32'h1400, 32'h1600, 0};
    vecs[4] = '{32'd0, 2, 25'h0, 1'b1, 0, 0, 1'b1, 20,
                21, 1'b0, 1'b1, 0, 1, 32'h0, 32'h0, 0};
    vecs[5] = '{32'h100, 1, 25'h1000, 1'b1, 0, 2, 1'b1, -1,
                256, 1'b0, 1'b0, 1, 1, 32'h20000, 32'h20000, 0};

    repeat (2) @(negedge clk);
    check_reset_outputs("rst0");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_job(vecs[i], i);

    // zero-length job: done one cycle after start, no bus traffic
    num_sectors = 16'd0;
    start = 1'b1;
    c0 = cs_cycles;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    @(negedge clk);
    check("zero_done_drop", done, 0);
    check("zero_bus", cs_cycles - c0, 0);

    // reset in the middle of the second sector
    card_present = 1'b1;
    err_cmd      = 0;
    poll_busy    = 0;
    stall_en     = 1'b0;
    abort_at     = -1;
    job_id++;
    @(negedge clk);
    start_sector = 32'd1;
    num_sectors  = 16'd3;
    sdram_base   = 25'h0;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (sectors_done != 16'd1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_sector_reached", sectors_done, 1);
    repeat (50) @(negedge clk);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // swapped-halves, block-addressed build
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 1;
    seen = done2;
    while (!seen && n < 2000) begin
      @(negedge clk);
      n++;
      seen = done2;
    end
    check("swap_done_seen", seen, 1);
    check("swap_cycles", n, 389);
    check("swap_sectors", sectors_done2, 1);
    check("swap_arg", arg2, 32'd5);
    check("swap_nwrites", w2.size(), 256);
    if (w2.size() >= 4) begin
      check("swap_w0", w2[0], 16'hA500);
      check("swap_w1", w2[1], 16'h0000);
      check("swap_w3", w2[3], 16'h0001);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
